// File: rtl/io_ram_bridge.sv
// io_ram_bridge
//
// Bridges the single-cycle ram-side strobes of the SPI data client onto the
// SDRAM host interface. Requests are queued in a small FIFO and each one is
// issued only in the IO bus-cycle slot, so IO traffic never steals a CPU or
// video slot. Reads return their data with a one-cycle valid pulse two cycles
// after the issuing edge.
//
// Ports:
//   clk_8      in   8 MHz system clock, all logic on the rising edge
//   reset_n    in   synchronous active-low reset
//   bus_cycle  in   current SDRAM bus slot (advances once per clk_8)
//   io_read    in   single-cycle read request
//   io_write   in   single-cycle write request
//   io_addr    in   word address, valid with io_read/io_write
//   io_wdata   in   write data, valid with io_write
//   io_rdata   out  read data returned to the SPI data client
//   io_rvalid  out  one-cycle pulse, io_rdata updated this cycle
//   fifo_full  out  FIFO holds DEPTH entries
//   overflow   out  sticky: a request was dropped
//   proto_err  out  sticky: io_read and io_write asserted together
//   ram_addr   out  SDRAM word address (holds between issues)
//   ram_oe     out  SDRAM read strobe, one cycle
//   ram_we     out  SDRAM write strobe, one cycle
//   ram_wdata  out  SDRAM write data (holds between issues)
//   ram_rdata  in   SDRAM read data, valid one cycle after ram_oe
module io_ram_bridge #(
  parameter int DEPTH   = 4,
  parameter int AW      = 23,
  parameter int IO_SLOT = 3
) (
  input  logic          clk_8,
  input  logic          reset_n,
  input  logic [1:0]    bus_cycle,
  input  logic          io_read,
  input  logic          io_write,
  input  logic [AW-1:0] io_addr,
  input  logic [15:0]   io_wdata,
  output logic [15:0]   io_rdata,
  output logic          io_rvalid,
  output logic          fifo_full,
  output logic          overflow,
  output logic          proto_err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_oe,
  output logic          ram_we,
  output logic [15:0]   ram_wdata,
  input  logic [15:0]   ram_rdata
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [1:0]    SLOT     = 2'(IO_SLOT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_t;

  state_t state;
  state_t state_next;

  // FIFO storage: one entry = {we, addr, data}. Data-only, so no reset.
  logic          mem_we   [DEPTH];
  logic [AW-1:0] mem_addr [DEPTH];
  logic [15:0]   mem_data [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic push_req;
  logic push_ok;
  logic pop;

  // A simultaneous read+write still produces one request: the write wins.
  assign push_req  = io_write | io_read;
  // A pop in the same cycle frees a slot, so a push while full is accepted.
  assign push_ok   = push_req && ((count != FULL_CNT) || pop);
  assign fifo_full = (count == FULL_CNT);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && (bus_cycle == SLOT)) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      // ram_oe is only high in ISSUE for a read entry.
      ISSUE:   state_next = ram_oe ? CAPTURE : IDLE;
      CAPTURE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_8) begin
    if (reset_n && push_ok) begin
      mem_we[wr_ptr]   <= io_write;
      mem_addr[wr_ptr] <= io_addr;
      mem_data[wr_ptr] <= io_wdata;
    end
  end

  always_ff @(posedge clk_8) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ram_oe    <= 1'b0;
      ram_we    <= 1'b0;
      io_rvalid <= 1'b0;
      io_rdata  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_next;

      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push_ok) - CW'(pop);

      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end
      if (io_read && io_write) begin
        proto_err <= 1'b1;
      end

      // Strobes are high only for the ISSUE cycle that follows the pop.
      ram_we <= pop && mem_we[rd_ptr];
      ram_oe <= pop && !mem_we[rd_ptr];
      if (pop) begin
        ram_addr  <= mem_addr[rd_ptr];
        ram_wdata <= mem_data[rd_ptr];
      end

      // ram_rdata is valid in the CAPTURE cycle; present it the cycle after.
      io_rvalid <= (state == CAPTURE);
      if (state == CAPTURE) begin
        io_rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_io_ram_bridge.sv
// tb_io_ram_bridge
//
// Directed and randomized stimulus for io_ram_bridge. A transaction-level
// reference model (a request queue, a busy window after each issue and a
// word memory) predicts every output after each clock edge. A small SDRAM
// model answers ram_oe one cycle later.
module tb_io_ram_bridge;

  localparam int DEPTH   = 4;
  localparam int AW      = 23;
  localparam int IO_SLOT = 3;

  logic          clk_8;
  logic          reset_n;
  logic [1:0]    bus_cycle;
  logic          io_read;
  logic          io_write;
  logic [AW-1:0] io_addr;
  logic [15:0]   io_wdata;
  logic [15:0]   io_rdata;
  logic          io_rvalid;
  logic          fifo_full;
  logic          overflow;
  logic          proto_err;
  logic [AW-1:0] ram_addr;
  logic          ram_oe;
  logic          ram_we;
  logic [15:0]   ram_wdata;
  logic [15:0]   ram_rdata;

  io_ram_bridge #(
    .DEPTH  (DEPTH),
    .AW     (AW),
    .IO_SLOT(IO_SLOT)
  ) dut (
    .clk_8    (clk_8),
    .reset_n  (reset_n),
    .bus_cycle(bus_cycle),
    .io_read  (io_read),
    .io_write (io_write),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .io_rvalid(io_rvalid),
    .fifo_full(fifo_full),
    .overflow (overflow),
    .proto_err(proto_err),
    .ram_addr (ram_addr),
    .ram_oe   (ram_oe),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  initial clk_8 = 1'b0;
  always #5 clk_8 = ~clk_8;

  // SDRAM model: writes land on ram_we, read data appears one cycle after
  // ram_oe and is a poison value at any other time.
  logic [15:0] env_mem [1024];
  always @(posedge clk_8) begin
    if (ram_we === 1'b1) env_mem[ram_addr[9:0]] <= ram_wdata;
    ram_rdata <= (ram_oe === 1'b1) ? env_mem[ram_addr[9:0]] : 16'hA5A5;
  end

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } ent_t;

  // Reference model state
  ent_t          q[$];
  logic [15:0]   model_mem [logic [AW-1:0]];
  int            edge_n;
  int            free_edge;
  bit            rv_pend;
  int            rv_edge;
  logic [15:0]   rv_data;
  bit            m_ovf, m_perr, wd_known;
  logic          e_we, e_oe, e_rv, e_full;
  logic [15:0]   e_rdata, e_wdata;
  logic [AW-1:0] e_addr;

  int  tests, fails;
  int  we_cnt, oe_cnt, rv_cnt;
  bit  hold_bus;
  int  bc_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mm_rd(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : 16'h0000;
  endfunction

  task automatic model_step(input bit rn, input logic [1:0] bus, input bit rd,
                            input bit wr, input logic [AW-1:0] a, input logic [15:0] d);
    ent_t e;
    bit   pop;
    edge_n++;
    if (!rn) begin
      q.delete();
      rv_pend = 0; free_edge = 0; m_ovf = 0; m_perr = 0; wd_known = 1;
      e_we = 0; e_oe = 0; e_rv = 0; e_full = 0;
      e_rdata = '0; e_wdata = '0; e_addr = '0;
      return;
    end
    e_we = 0; e_oe = 0; e_rv = 0;
    if (rv_pend && rv_edge == edge_n) begin
      e_rv = 1; e_rdata = rv_data; rv_pend = 0;
    end
    pop = (q.size() > 0) && (bus == 2'(IO_SLOT)) && (edge_n >= free_edge);
    if (pop) begin
      e = q.pop_front();
      e_addr = e.addr;
      if (e.we) begin
        e_we = 1; e_wdata = e.data; wd_known = 1;
        model_mem[e.addr] = e.data;
        free_edge = edge_n + 2;          // one ISSUE cycle
      end else begin
        e_oe = 1; wd_known = 0;
        rv_pend = 1; rv_edge = edge_n + 2; rv_data = mm_rd(e.addr);
        free_edge = edge_n + 3;          // ISSUE then CAPTURE
      end
    end
    if (rd && wr) m_perr = 1;
    if (rd || wr) begin
      if (q.size() < DEPTH) begin
        e.we = wr; e.addr = a; e.data = d;
        q.push_back(e);
      end else begin
        m_ovf = 1;
      end
    end
    e_full = (q.size() == DEPTH);
  endtask

  task automatic check_all();
    chk("ram_we", ram_we, e_we);
    chk("ram_oe", ram_oe, e_oe);
    chk("io_rvalid", io_rvalid, e_rv);
    chk("io_rdata", io_rdata, e_rdata);
    chk("fifo_full", fifo_full, e_full);
    chk("overflow", overflow, m_ovf);
    chk("proto_err", proto_err, m_perr);
    chk("ram_addr", ram_addr, e_addr);
    if (wd_known) chk("ram_wdata", ram_wdata, e_wdata);
  endtask

  task automatic tick(input bit rn, input bit rd, input bit wr,
                      input logic [AW-1:0] a, input logic [15:0] d);
    logic [1:0] bus;
    bus = hold_bus ? 2'd0 : 2'(bc_cnt);
    if (!hold_bus) bc_cnt = (bc_cnt + 1) % 4;
    reset_n = rn; bus_cycle = bus; io_read = rd; io_write = wr;
    io_addr = a; io_wdata = d;
    @(posedge clk_8);
    model_step(rn, bus, rd, wr, a, d);
    #1;
    io_read = 1'b0; io_write = 1'b0;
    check_all();
    if (ram_we === 1'b1) we_cnt++;
    if (ram_oe === 1'b1) oe_cnt++;
    if (io_rvalid === 1'b1) rv_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, '0, '0);
  endtask

  task automatic clr_counts();
    we_cnt = 0; oe_cnt = 0; rv_cnt = 0;
  endtask

  initial begin
    bit found;
    int r;
    reset_n = 1'b0; bus_cycle = 2'd0; io_read = 1'b0; io_write = 1'b0;
    io_addr = '0; io_wdata = '0;
    tests = 0; fails = 0; hold_bus = 0; bc_cnt = 0;
    edge_n = 0; free_edge = 0; rv_pend = 0; wd_known = 1;
    clr_counts();

    // Reset state
    tick(0, 0, 0, '0, '0);
    tick(0, 0, 0, '0, '0);
    chk("rst_rvalid", io_rvalid, 1'b0);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_addr", ram_addr, 23'h0);

    // Single write issued in the IO slot
    clr_counts();
    tick(1, 0, 1, 23'h000100, 16'hBEEF);
    idle(8);
    chk("t1_we_pulses", we_cnt, 1);
    chk("t1_oe_pulses", oe_cnt, 0);
    chk("t1_wdata", ram_wdata, 16'hBEEF);

    // Write then read-back of the same address
    clr_counts();
    tick(1, 0, 1, 23'h10, 16'h1234);
    tick(1, 1, 0, 23'h10, 16'h0000);
    idle(12);
    chk("t2_we_pulses", we_cnt, 1);
    chk("t2_oe_pulses", oe_cnt, 1);
    chk("t2_rv_pulses", rv_cnt, 1);
    chk("t2_rdata", io_rdata, 16'h1234);

    // Fill with bus held off the slot, overflow on the 5th push, then drain
    tick(0, 0, 0, '0, '0);
    hold_bus = 1;
    clr_counts();
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 1, 23'(32'h40 + i), 16'(32'h1000 + i));
      if (i == 3) chk("t3_full4", fifo_full, 1'b1);
    end
    chk("t3_overflow", overflow, 1'b1);
    hold_bus = 0;
    idle(24);
    chk("t3_we_pulses", we_cnt, 4);

    // Push coinciding with a pop while full
    tick(0, 0, 0, '0, '0);
    hold_bus = 1;
    clr_counts();
    for (int i = 0; i < 4; i++) tick(1, 0, 1, 23'(32'h50 + i), 16'(32'h2000 + i));
    hold_bus = 0;
    bc_cnt = IO_SLOT;
    tick(1, 0, 1, 23'h60, 16'hCAFE);
    chk("t4_full", fifo_full, 1'b1);
    chk("t4_overflow", overflow, 1'b0);
    idle(24);
    chk("t4_we_pulses", we_cnt, 5);

    // Read and write together
    tick(0, 0, 0, '0, '0);
    clr_counts();
    tick(1, 1, 1, 23'h20, 16'h5555);
    chk("t5_perr", proto_err, 1'b1);
    idle(10);
    chk("t5_we_pulses", we_cnt, 1);
    chk("t5_oe_pulses", oe_cnt, 0);

    // Give addresses 0..15 known contents for the random reads
    for (int i = 0; i < 16; i++) begin
      tick(1, 0, 1, 23'(i), 16'($urandom));
      idle(3);
    end
    idle(8);

    // Reset right after a read issues
    tick(1, 1, 0, 23'h5, 16'h0);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (e_oe) found = 1;
      else idle(1);
    end
    chk("t6_oe_seen", found, 1'b1);
    clr_counts();
    tick(0, 0, 0, '0, '0);
    idle(6);
    chk("t6_rv_pulses", rv_cnt, 0);
    chk("t6_full", fifo_full, 1'b0);
    chk("t6_overflow", overflow, 1'b0);
    chk("t6_perr", proto_err, 1'b0);
    chk("t6_oe", ram_oe, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if (i % 40 == 0) hold_bus = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 31);
      if (r < 8)       tick(1, 0, 1, 23'($urandom_range(0, 15)), 16'($urandom));
      else if (r < 14) tick(1, 1, 0, 23'($urandom_range(0, 15)), 16'($urandom));
      else if (r == 14) tick(1, 1, 1, 23'($urandom_range(0, 15)), 16'($urandom));
      else             idle(1);
    end
    hold_bus = 0;
    idle(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_ram_bridge.md
Name: io_ram_bridge

Overview:
- Sits directly downstream of the SPI data client, between that block's ram-side strobes (read/write/addr/data_out/data_in) and the SDRAM host interface.
- Buffers single-cycle IO read/write requests in a small FIFO.
- Issues each request to SDRAM only in the IO bus-cycle slot, so IO traffic never collides with CPU/video slots.
- Returns read data with a one-cycle valid pulse.

Parameters:
DEPTH, 4, FIFO entries (power of 2, 2..16)
AW, 23, word address width
IO_SLOT, 3, bus_cycle value in which IO accesses are issued

Ports:
clk_8  in  1  8 MHz system clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
bus_cycle  in  2  current SDRAM bus slot, advances once per clk_8
io_read  in  1  single-cycle read request pulse from SPI data client
io_write  in  1  single-cycle write request pulse from SPI data client
io_addr  in  AW  word address, valid with io_read/io_write
io_wdata  in  16  write data, valid with io_write
io_rdata  out  16  read data returned to SPI data client
io_rvalid  out  1  one-cycle pulse, io_rdata updated this cycle
fifo_full  out  1  FIFO holds DEPTH entries
overflow  out  1  sticky: a request was dropped
proto_err  out  1  sticky: io_read and io_write asserted together
ram_addr  out  AW  SDRAM word address
ram_oe  out  1  SDRAM read strobe, one cycle
ram_we  out  1  SDRAM write strobe, one cycle
ram_wdata  out  16  SDRAM write data
ram_rdata  in  16  SDRAM read data, valid one cycle after ram_oe

Behaviour:
- Reset (reset_n low at a posedge):
  - FIFO flushed (rd/wr pointers and count = 0).
  - State = IDLE.
  - ram_oe = ram_we = 0; io_rvalid = 0.
  - io_rdata, ram_addr, ram_wdata = 0.
  - overflow = proto_err = 0.
  - Reset mid-operation discards any queued or in-flight request. A capture pending at reset is not delivered.
- Enqueue:
  - On a posedge with io_write = 1, push {we = 1, io_addr, io_wdata}.
  - On a posedge with io_read = 1 and io_write = 0, push {we = 0, io_addr, don't-care data}.
  - Both asserted: the write is pushed, the read is dropped, and proto_err is set.
- Full:
  - A push when count == DEPTH and no pop in the same cycle is dropped; overflow is set.
  - Push and pop in the same cycle while full: the push is accepted and count is unchanged.
- fifo_full is combinational from count (count == DEPTH).
- Empty: no issue and no strobes.
- State machine: IDLE, ISSUE, CAPTURE.
  - IDLE -> ISSUE when the FIFO is not empty and bus_cycle == IO_SLOT at the posedge.
    - The head entry is popped.
    - ram_addr and ram_wdata are loaded from the head entry.
    - ram_we (write entry) or ram_oe (read entry) is set to 1.
  - ISSUE lasts exactly one cycle; the strobe is high for only that cycle.
    - Write entry: ISSUE -> IDLE, strobe cleared.
    - Read entry: ISSUE -> CAPTURE, strobe cleared.
  - CAPTURE lasts one cycle: io_rdata <= ram_rdata, io_rvalid = 1 for that cycle, then -> IDLE.
- Latency and ordering:
  - A request pushed at posedge t can issue at the earliest at t+1, if bus_cycle == IO_SLOT there. Otherwise it issues at the next IO_SLOT cycle.
  - Read data is valid (io_rvalid) two cycles after the issuing posedge.
  - Because the slot period is 4 cycles, CAPTURE always finishes before the next slot. At most one access is issued per slot.
  - Requests complete strictly in push order; a read after a write to the same address returns the new data.
- ram_addr and ram_wdata hold their last value between issues.
- Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- overflow and proto_err clear only on reset.

Test Plan:
- Reset, then io_write addr=0x000100 data=0xBEEF with bus_cycle cycling 0..3 -> exactly one ram_we pulse in the IO_SLOT cycle, ram_addr=0x000100, ram_wdata=0xBEEF, no ram_oe.
- Write 0x1234 to 0x10, then read 0x10; model returns ram_rdata=0x1234 one cycle after ram_oe -> ram_we issues in the first slot and ram_oe in the next. io_rvalid pulses for one cycle 2 cycles after ram_oe's posedge, io_rdata=0x1234.
- Push 5 writes back-to-back, DEPTH=4, while bus_cycle held at 0 -> fifo_full=1 after the 4th push, 5th dropped, overflow=1. Then release bus_cycle -> 4 ram_we pulses in push order, 4 cycles apart.
- Full FIFO, push coinciding with a pop at IO_SLOT -> push accepted, overflow stays 0, fifo_full stays 1.
- io_read and io_write in the same cycle at addr=0x20 -> one write entry queued, proto_err=1, no ram_oe issued.
- Read issued (ram_oe high), reset_n low on the next posedge -> io_rvalid never pulses, FIFO empty, all strobes 0, sticky flags cleared.
